// File: rtl/ccc_div_gen.sv
// Multi-channel clock-enable / divided-clock generator on a single clock domain.
// Each channel has a programmable ratio, start delay and bypass; LOCK reports settled config.
module ccc_div_gen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 5,
  parameter int DLY_W       = 5,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LOCK_W     = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic [DLY_W-1:0]  CFG_DLY,
  input  logic              CFG_BYPASS,
  output logic [NUM_CH-1:0] EN_OUT,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic              LOCK
);

  typedef enum logic {
    ST_DELAY = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  div_d   [NUM_CH];
  logic [DLY_W-1:0]  dly_q   [NUM_CH];
  logic [DLY_W-1:0]  dly_d   [NUM_CH];
  logic              bypass_q[NUM_CH];
  logic              bypass_d[NUM_CH];
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [DLY_W-1:0]  dcnt_q  [NUM_CH];
  logic [DLY_W-1:0]  dcnt_d  [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_d   [NUM_CH];
  logic [DIV_W:0]    half    [NUM_CH];
  logic [LOCK_W-1:0] lock_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_d;
  logic              cfg_hit;
  logic              all_run;

  // Writes addressed past the last channel are dropped, including their effect on LOCK.
  assign cfg_hit = CFG_WE && (32'(CFG_CH) < 32'(NUM_CH));

  // NOTE: every variable gets its default before any branch, so no path can leave one unassigned and infer a latch.
  always_comb begin
    all_run = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]    = div_q[i];
      dly_d[i]    = dly_q[i];
      bypass_d[i] = bypass_q[i];
      state_d[i]  = state_q[i];
      dcnt_d[i]   = dcnt_q[i];
      cnt_d[i]    = cnt_q[i];

      if (!(state_q[i] == ST_RUN || bypass_q[i])) all_run = 1'b0;

      if (cfg_hit && CFG_CH == CH_W'(i)) begin
        div_d[i]    = CFG_DIV;
        dly_d[i]    = CFG_DLY;
        bypass_d[i] = CFG_BYPASS;
        state_d[i]  = ST_DELAY;
        dcnt_d[i]   = CFG_DLY;
        cnt_d[i]    = '0;
      end else begin
        case (state_q[i])
          ST_DELAY: begin
            if (dcnt_q[i] == '0) begin
              state_d[i] = ST_RUN;
              cnt_d[i]   = '0;
            end else begin
              dcnt_d[i] = dcnt_q[i] - DLY_W'(1);
            end
          end
          ST_RUN: begin
            if (bypass_q[i] || cnt_q[i] == div_q[i]) cnt_d[i] = '0;
            else                                     cnt_d[i] = cnt_q[i] + DIV_W'(1);
          end
          default: state_d[i] = ST_DELAY;
        endcase
      end
    end

    lock_cnt_d = lock_cnt_q;
    if (cfg_hit)
      lock_cnt_d = '0;
    else if (all_run && lock_cnt_q < LOCK_W'(LOCK_CYCLES))
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: the per-channel arrays are plain flops, not RAM, so they are reset like any other register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]    <= '0;
        dly_q[i]    <= '0;
        bypass_q[i] <= 1'b0;
        state_q[i]  <= ST_DELAY;
        dcnt_q[i]   <= '0;
        cnt_q[i]    <= '0;
      end
      lock_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]    <= div_d[i];
        dly_q[i]    <= dly_d[i];
        bypass_q[i] <= bypass_d[i];
        state_q[i]  <= state_d[i];
        dcnt_q[i]   <= dcnt_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Moore decode: high phase lasts ceil(R/2) cycles; H needs one extra bit so div=max cannot wrap.
  always_comb begin
    EN_OUT  = '0;
    CLK_OUT = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      half[i]    = ({1'b0, div_q[i]} + (DIV_W+1)'(2)) >> 1;
      EN_OUT[i]  = bypass_q[i] || (state_q[i] == ST_RUN && cnt_q[i] == div_q[i]);
      CLK_OUT[i] = bypass_q[i] || (state_q[i] == ST_RUN && {1'b0, cnt_q[i]} < half[i]);
    end
  end

  assign LOCK = (lock_cnt_q == LOCK_W'(LOCK_CYCLES));

endmodule

// File: tb/tb_ccc_div_gen.sv
// Bench for ccc_div_gen: directed scenarios with literal expectations plus random
// config traffic compared every cycle against a timeline model of each channel.
module tb_ccc_div_gen;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 5;
  localparam int DLY_W  = 5;
  localparam int LC     = 16;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              CFG_WE = 1'b0;
  logic [CH_W-1:0]   CFG_CH = '0;
  logic [DIV_W-1:0]  CFG_DIV = '0;
  logic [DLY_W-1:0]  CFG_DLY = '0;
  logic              CFG_BYPASS = 1'b0;
  logic [NUM_CH-1:0] EN_OUT;
  logic [NUM_CH-1:0] CLK_OUT;
  logic              LOCK;

  ccc_div_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DLY_W(DLY_W), .LOCK_CYCLES(LC)) dut (
    .CLK(CLK), .RESET(RESET), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_DIV(CFG_DIV),
    .CFG_DLY(CFG_DLY), .CFG_BYPASS(CFG_BYPASS), .EN_OUT(EN_OUT), .CLK_OUT(CLK_OUT), .LOCK(LOCK)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each channel is described by when it was configured and with what; the waveform
  // follows from the edge index alone. m_w is the last edge that restarted the lock count.
  int  m_n = 0;
  int  m_w = 0;
  bit  m_valid = 0;
  int  m_div [NUM_CH];
  int  m_dly [NUM_CH];
  bit  m_byp [NUM_CH];
  int  m_tcfg[NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, m_n, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit we, input int ch, input int div,
                            input int dly, input bit byp);
    m_n++;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i] = 0; m_dly[i] = 0; m_byp[i] = 0; m_tcfg[i] = m_n;
      end
      m_w = m_n;
      m_valid = 1;
    end else if (we && ch < NUM_CH) begin
      m_div[ch] = div; m_dly[ch] = dly; m_byp[ch] = byp; m_tcfg[ch] = m_n;
      m_w = m_n;
    end
  endtask

  function automatic void model_out(output logic [NUM_CH-1:0] en, output logic [NUM_CH-1:0] ck,
                                    output logic lk);
    int settle = m_w;
    en = '0;
    ck = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int run_start = m_tcfg[i] + m_dly[i] + 1;
      int r = m_div[i] + 1;
      if (m_byp[i]) begin
        en[i] = 1'b1;
        ck[i] = 1'b1;
      end else begin
        if (run_start > settle) settle = run_start;
        if (m_n >= run_start) begin
          int k = (m_n - run_start) % r;
          en[i] = (k == m_div[i]);
          ck[i] = (k < (r + 1) / 2);
        end
      end
    end
    lk = (m_n - settle) >= LC;
  endfunction

  always @(negedge CLK) begin
    if (m_valid) begin
      logic [NUM_CH-1:0] e_en, e_ck;
      logic e_lk;
      model_out(e_en, e_ck, e_lk);
      check("model_en_out",  32'(EN_OUT),  32'(e_en));
      check("model_clk_out", 32'(CLK_OUT), 32'(e_ck));
      check("model_lock",    32'(LOCK),    32'(e_lk));
    end
  end

  task automatic cyc(input bit rst, input bit we, input int ch, input int div,
                     input int dly, input bit byp);
    RESET      = rst;
    CFG_WE     = we;
    CFG_CH     = ch[CH_W-1:0];
    CFG_DIV    = div[DIV_W-1:0];
    CFG_DLY    = dly[DLY_W-1:0];
    CFG_BYPASS = byp;
    @(posedge CLK);
    model_edge(rst, we, ch, div, dly, byp);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input int div, input int dly, input bit byp);
    cyc(0, 1, ch, div, dly, byp);
  endtask

  initial begin
    logic [7:0] ck_seq;
    logic [7:0] en_seq;

    // Reset, then release with no writes.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    check("rst_en_out",  32'(EN_OUT),  32'h0);
    check("rst_clk_out", 32'(CLK_OUT), 32'h0);
    check("rst_lock",    32'(LOCK),    32'h0);
    idle(1);
    check("release_en_out",  32'(EN_OUT),  32'h7);
    check("release_clk_out", 32'(CLK_OUT), 32'h7);
    idle(15);
    check("lock_not_yet", 32'(LOCK), 32'h0);
    idle(1);
    check("lock_rise", 32'(LOCK), 32'h1);

    // ch1 ratio 4, no delay: 1100 clock pattern, enable on the last low cycle.
    wr(1, 3, 0, 0);
    check("lock_drop", 32'(LOCK), 32'h0);
    ck_seq = '0;
    en_seq = '0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      ck_seq = {ck_seq[6:0], CLK_OUT[1]};
      en_seq = {en_seq[6:0], EN_OUT[1]};
    end
    check("ch1_div4_clk", 32'(ck_seq), 32'hCC);
    check("ch1_div4_en",  32'(en_seq), 32'h11);
    idle(20);
    check("lock_relock", 32'(LOCK), 32'h1);

    // Out-of-range channel must not disturb LOCK.
    wr(3, 0, 9, 0);
    check("bad_ch_lock", 32'(LOCK), 32'h1);

    // ch0 ratio 5: high 3, low 2, enable on the last low cycle.
    wr(0, 4, 0, 0);
    ck_seq = '0;
    en_seq = '0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      ck_seq = {ck_seq[6:0], CLK_OUT[0]};
      en_seq = {en_seq[6:0], EN_OUT[0]};
    end
    check("ch0_div5_clk", 32'(ck_seq), 32'h1C);
    check("ch0_div5_en",  32'(en_seq), 32'h01);

    // ch2 held in a long delay, then bypassed: forced high immediately.
    wr(2, 5, 20, 0);
    idle(2);
    wr(2, 5, 20, 1);
    check("bypass_en",  32'(EN_OUT[2]),  32'h1);
    check("bypass_clk", 32'(CLK_OUT[2]), 32'h1);
    idle(5);

    // Same ratio, fixed phase offset of (1 write cycle + 2 delay).
    wr(0, 7, 0, 0);
    wr(2, 7, 2, 0);
    idle(40);

    // Rewrite mid-delay restarts timing from the second write.
    wr(1, 2, 10, 0);
    idle(3);
    wr(1, 2, 1, 0);
    idle(30);

    // Reset mid-run.
    cyc(1, 0, 0, 0, 0, 0);
    check("midrst_en_out", 32'(EN_OUT), 32'h0);
    check("midrst_lock",   32'(LOCK),   32'h0);
    idle(25);

    // Random traffic, alternating busy and quiet blocks so LOCK both falls and rises.
    for (int blk = 0; blk < 12; blk++) begin
      int p = (blk % 2 == 0) ? 5 : 0;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 399) == 0) begin
          cyc(1, 0, 0, 0, 0, 0);
        end else if (p != 0 && $urandom_range(0, p - 1) == 0) begin
          int ch  = $urandom_range(0, 3);
          int div = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
          int dly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
          bit byp = ($urandom_range(0, 5) == 0);
          wr(ch, div, dly, byp);
        end else begin
          idle(1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
